// File: rtl/tlb_req_arbiter.sv
// Round-robin arbiter sharing one TLB translation port between NUM_REQ requesters.
// One transaction in flight; a response watchdog forces a fault if the TLB stalls.
module tlb_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [32*NUM_REQ-1:0]   vaddr_i,
  input  logic [NUM_REQ-1:0]      access_type_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,
  output logic [31:0]             paddr_o,
  output logic                    hit_o,
  output logic                    fault_o,
  output logic                    tlb_req_valid_o,
  input  logic                    tlb_req_ready_i,
  output logic [31:0]             tlb_vaddr_o,
  output logic                    tlb_access_type_o,
  input  logic                    tlb_resp_valid_i,
  output logic                    tlb_resp_ready_o,
  input  logic [31:0]             tlb_paddr_i,
  input  logic                    tlb_hit_i,
  input  logic                    tlb_fault_i,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    timeout_o,
  output logic [1:0]              state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both 1. A valid source keeps valid and payload stable until the transfer.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [31:0]        vaddr_q, vaddr_d;
  logic               type_q, type_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               hit_q, hit_d;
  logic               fault_q, fault_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;

  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_REQ-1:0] resp_valid_c;
  logic               tlb_req_valid_c;
  logic               tlb_resp_ready_c;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    vaddr_d          = vaddr_q;
    type_d           = type_q;
    paddr_d          = paddr_q;
    hit_d            = hit_q;
    fault_d          = fault_q;
    timeout_d        = timeout_q;
    cnt_d            = cnt_q;
    req_ready_c      = '0;
    resp_valid_c     = '0;
    tlb_req_valid_c  = 1'b0;
    tlb_resp_ready_c = 1'b0;

    case (state_q)
      IDLE: begin
        // Late responses from a timed-out transaction are drained here.
        tlb_resp_ready_c = 1'b1;
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          vaddr_d              = vaddr_i[32*int'(gnt_idx) +: 32];
          type_d               = access_type_i[gnt_idx];
          grant_d              = gnt_idx;
          state_d              = ISSUE;
        end
      end

      ISSUE: begin
        tlb_req_valid_c = 1'b1;
        if (tlb_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        tlb_resp_ready_c = 1'b1;
        if (tlb_resp_valid_i) begin
          // A real response beats a watchdog expiry in the same cycle.
          paddr_d = tlb_paddr_i;
          hit_d   = tlb_hit_i;
          fault_d = tlb_fault_i;
          state_d = DELIVER;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          paddr_d   = '0;
          hit_d     = 1'b0;
          fault_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = DELIVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DELIVER: begin
        tlb_resp_ready_c      = 1'b1;
        resp_valid_c[grant_q] = 1'b1;
        if (resp_ready_i[grant_q]) begin
          if (int'(grant_q) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_q + 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      vaddr_q   <= '0;
      type_q    <= 1'b0;
      paddr_q   <= '0;
      hit_q     <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      vaddr_q   <= vaddr_d;
      type_q    <= type_d;
      paddr_q   <= paddr_d;
      hit_q     <= hit_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted, even in IDLE.
  assign req_ready_o      = req_ready_c  & {NUM_REQ{rst_n}};
  assign resp_valid_o     = resp_valid_c & {NUM_REQ{rst_n}};
  assign tlb_req_valid_o  = tlb_req_valid_c  & rst_n;
  assign tlb_resp_ready_o = tlb_resp_ready_c & rst_n;

  assign tlb_vaddr_o       = vaddr_q;
  assign tlb_access_type_o = type_q;
  assign paddr_o           = paddr_q;
  assign hit_o             = hit_q;
  assign fault_o           = fault_q;
  assign grant_idx_o       = grant_q;
  assign timeout_o         = timeout_q;
  assign state_o           = state_q;

`ifndef SYNTHESIS
  a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready_o));

  a_resp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(resp_valid_o));

  a_issue_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (tlb_req_valid_o && !tlb_req_ready_i) |=>
      (tlb_req_valid_o && $stable(tlb_vaddr_o) && $stable(tlb_access_type_o)));

  a_deliver_stable: assert property (@(posedge clk) disable iff (!rst_n)
    ((|resp_valid_o) && !resp_ready_i[grant_idx_o]) |=>
      ((resp_valid_o == $past(resp_valid_o)) && $stable({paddr_o, hit_o, fault_o})));
`endif

endmodule

// File: tb/tb_tlb_req_arbiter.sv
// Self-checking bench for tlb_req_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin/watchdog model.
module tb_tlb_req_arbiter;

  localparam int N = 2;
  localparam int T = 8;
  localparam int W = 34;
  localparam int NEVER = 1000;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [32*N-1:0]   vaddr_i;
  logic [N-1:0]      access_type_i;
  logic [N-1:0]      resp_valid_o;
  logic [N-1:0]      resp_ready_i;
  logic [31:0]       paddr_o;
  logic              hit_o;
  logic              fault_o;
  logic              tlb_req_valid_o;
  logic              tlb_req_ready_i;
  logic [31:0]       tlb_vaddr_o;
  logic              tlb_access_type_o;
  logic              tlb_resp_valid_i;
  logic              tlb_resp_ready_o;
  logic [31:0]       tlb_paddr_i;
  logic              tlb_hit_i;
  logic              tlb_fault_i;
  logic              grant_idx_o;
  logic              timeout_o;
  logic [1:0]        state_o;

  tlb_req_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .vaddr_i(vaddr_i),
    .access_type_i(access_type_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .paddr_o(paddr_o),
    .hit_o(hit_o),
    .fault_o(fault_o),
    .tlb_req_valid_o(tlb_req_valid_o),
    .tlb_req_ready_i(tlb_req_ready_i),
    .tlb_vaddr_o(tlb_vaddr_o),
    .tlb_access_type_o(tlb_access_type_o),
    .tlb_resp_valid_i(tlb_resp_valid_i),
    .tlb_resp_ready_o(tlb_resp_ready_o),
    .tlb_paddr_i(tlb_paddr_i),
    .tlb_hit_i(tlb_hit_i),
    .tlb_fault_i(tlb_fault_i),
    .grant_idx_o(grant_idx_o),
    .timeout_o(timeout_o),
    .state_o(state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {fault, hit, paddr} per transaction, in order.
  logic [W-1:0] exp_q[$];

  // Reference model: the port served last has lowest priority next time.
  int   next_prio_m = 0;
  logic timeout_m   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i      = '0;
    vaddr_i          = '0;
    access_type_i    = '0;
    resp_ready_i     = '0;
    tlb_req_ready_i  = 1'b0;
    tlb_resp_valid_i = 1'b0;
    tlb_paddr_i      = '0;
    tlb_hit_i        = 1'b0;
    tlb_fault_i      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_hs"}, {req_ready_o, resp_valid_o, tlb_req_valid_o, tlb_resp_ready_o}, '0);
    check_eq({tag, "_latched"}, {tlb_vaddr_o, tlb_access_type_o, paddr_o, hit_o, fault_o}, '0);
    check_eq({tag, "_grant_to"}, {grant_idx_o, timeout_o}, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    next_prio_m = 0;
    timeout_m   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. lat = WAIT_RESP cycle (counter value) in which the
  // TLB answers; lat >= T means the TLB stays silent and the watchdog fires.
  task automatic do_txn(input logic [N-1:0] mask, input int d_req, input int lat,
                        input int d_resp, input bit late_pulse,
                        input bit use_fix, input logic [31:0] va_fix, input logic [31:0] pa_fix);
    logic [31:0] va[N];
    logic        at[N];
    logic [31:0] pa;
    logic        h, f;
    logic [N-1:0] oh;
    logic [W-1:0] exp_rsp;
    int g;

    for (int k = 0; k < N; k++) begin
      va[k] = use_fix ? va_fix : $urandom;
      at[k] = use_fix ? 1'b0 : 1'($urandom_range(0, 1));
    end
    pa = use_fix ? pa_fix : $urandom;
    h  = use_fix ? 1'b1 : 1'($urandom_range(0, 1));
    f  = use_fix ? 1'b0 : 1'($urandom_range(0, 1));

    g = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (next_prio_m + k) % N;
      if (g < 0 && mask[c]) g = c;
    end
    oh    = '0;
    oh[g] = 1'b1;

    req_valid_i = mask;
    for (int k = 0; k < N; k++) begin
      vaddr_i[32*k +: 32] = va[k];
      access_type_i[k]    = at[k];
    end
    #1;
    check_eq("req_ready_grant", req_ready_o, oh);
    @(posedge clk);
    #1;

    for (int i = 0; i < d_req; i++) begin
      tlb_req_ready_i = 1'b0;
      #1;
      check_eq("issue_valid", tlb_req_valid_o, 1'b1);
      check_eq("issue_vaddr", tlb_vaddr_o, va[g]);
      check_eq("issue_type", tlb_access_type_o, at[g]);
      check_eq("issue_no_accept", {req_ready_o, tlb_resp_ready_o}, '0);
      check_eq("issue_grant_idx", grant_idx_o, g);
      @(posedge clk);
      #1;
    end
    tlb_req_ready_i = 1'b1;
    #1;
    check_eq("issue_hs_valid", tlb_req_valid_o, 1'b1);
    check_eq("issue_hs_vaddr", tlb_vaddr_o, va[g]);
    @(posedge clk);
    #1;
    tlb_req_ready_i = 1'b0;

    for (int c = 0; c < T; c++) begin
      if (c == lat) begin
        tlb_resp_valid_i = 1'b1;
        tlb_paddr_i      = pa;
        tlb_hit_i        = h;
        tlb_fault_i      = f;
      end
      #1;
      check_eq("wait_resp_ready", tlb_resp_ready_o, 1'b1);
      check_eq("wait_quiet", {req_ready_o, resp_valid_o, tlb_req_valid_o}, '0);
      @(posedge clk);
      #1;
      tlb_resp_valid_i = 1'b0;
      tlb_paddr_i      = $urandom;
      if (c == lat) break;
    end

    if (lat < T) begin
      exp_q.push_back({f, h, pa});
    end else begin
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      timeout_m = 1'b1;
    end
    exp_rsp = exp_q.pop_front();

    for (int i = 0; i < d_resp; i++) begin
      resp_ready_i = ~oh;
      #1;
      check_eq("deliver_valid", resp_valid_o, oh);
      check_eq("deliver_payload", {fault_o, hit_o, paddr_o}, exp_rsp);
      check_eq("deliver_no_accept", req_ready_o, '0);
      check_eq("deliver_timeout", timeout_o, timeout_m);
      @(posedge clk);
      #1;
    end
    resp_ready_i = oh | N'($urandom_range(0, (1 << N) - 1));
    #1;
    check_eq("deliver_hs_valid", resp_valid_o, oh);
    check_eq("deliver_hs_payload", {fault_o, hit_o, paddr_o}, exp_rsp);
    check_eq("deliver_grant_idx", grant_idx_o, g);
    check_eq("deliver_hs_timeout", timeout_o, timeout_m);
    @(posedge clk);
    #1;
    resp_ready_i = '0;
    req_valid_i  = '0;
    next_prio_m  = (g + 1) % N;
    #1;
    check_eq("idle_no_resp", resp_valid_o, '0);

    if (late_pulse) begin
      tlb_resp_valid_i = 1'b1;
      tlb_paddr_i      = $urandom;
      #1;
      check_eq("late_drain_ready", tlb_resp_ready_o, 1'b1);
      @(posedge clk);
      #1;
      tlb_resp_valid_i = 1'b0;
      #1;
      check_eq("late_no_resp", {resp_valid_o, tlb_req_valid_o}, '0);
      check_eq("late_timeout_sticky", timeout_o, timeout_m);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    apply_reset();

    // Single request on port 0 with fixed data.
    do_txn(2'b01, 0, 1, 0, 1'b0, 1'b1, 32'h0000_1234, 32'h0008_0234);

    // Contention from reset: grant order must alternate 0,1,0,1.
    apply_reset();
    for (int i = 0; i < 4; i++) do_txn(2'b11, 0, 0, 0, 1'b0, 1'b0, '0, '0);

    // Backpressure on both TLB request and owner response, owner = port 1.
    do_txn(2'b10, 5, 2, 3, 1'b0, 1'b0, '0, '0);

    // Response exactly on the expiry cycle wins over the watchdog.
    do_txn(2'b11, 0, T - 1, 1, 1'b0, 1'b0, '0, '0);
    check_eq("expiry_no_timeout", timeout_o, 1'b0);

    // Silent TLB: watchdog fault, then a late response drained in IDLE.
    do_txn(2'b01, 0, NEVER, 1, 1'b1, 1'b0, '0, '0);
    check_eq("timeout_set", timeout_o, 1'b1);
    do_txn(2'b11, 1, 3, 0, 1'b0, 1'b0, '0, '0);
    check_eq("timeout_still_set", timeout_o, 1'b1);

    // Async reset between edges while waiting for a response.
    req_valid_i = 2'b01;
    vaddr_i     = {32'h0, 32'hdead_beef};
    @(posedge clk);
    #1;
    req_valid_i     = 2'b11;
    tlb_req_ready_i = 1'b1;
    @(posedge clk);
    #1;
    tlb_req_ready_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("async_reset_held");
    req_valid_i = '0;
    rst_n       = 1'b1;
    next_prio_m = 0;
    timeout_m   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("post_reset_idle", {resp_valid_o, timeout_o}, '0);
    do_txn(2'b10, 0, 0, 0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] m;
      int lat;
      m   = N'($urandom_range(1, (1 << N) - 1));
      lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, T);
      do_txn(m, $urandom_range(0, 3), lat, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, '0, '0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
